regfile_writeback: RTL and testbench

- Write-side driver for the CPU register file: owns its single write port (write_en, write_address_0, write_data).
- Merges two result producers:
  - the single-cycle ALU path, which has no backpressure;
  - the long-latency memory/load path, which uses a valid/ready handshake and is buffered in a small FIFO.
- Arbitrates the two paths with starvation protection.
- Exports per-register busy status so the issue logic can avoid write-after-write and read-after-write hazards against writes still in flight.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/wb_fifo.sv | 87 ++++++++
 rtl/regfile_writeback.sv | 160 ++++++++++++++++
 tb/tb_regfile_writeback.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared CPU constants and types used by the register-file write-back logic.
//   DATA_WIDTH / ADDR_WIDTH : default register data and address widths
//   REG_ZERO                : index of the hard-wired zero register (x0)
//   wb_req_t                : one write-back request {addr, data}
// -----------------------------------------------------------------------------
package cpu_pkg;

   localparam int DATA_WIDTH = 32;
   localparam int ADDR_WIDTH = 5;

   localparam logic [ADDR_WIDTH-1:0] REG_ZERO = '0;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] data;
   } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// -----------------------------------------------------------------------------
// wb_fifo
// Synchronous FIFO holding pending memory/load write-back results.
// Ports:
//   clk, rst            : clock (rising edge), asynchronous active-high reset
//   push, push_addr/data: enqueue a result (ignored while full)
//   pop                 : dequeue the head (ignored while empty)
//   count, full, empty  : occupancy status
//   head_addr/head_data : oldest entry
//   entry_addrs         : per-slot destination address, flattened; slots that
//                         do not hold a live entry read as 0 so they can never
//                         match a non-zero hazard query
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module wb_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int DEPTH      = 4,
   localparam int PTR_W     = $clog2(DEPTH),
   localparam int CNT_W     = PTR_W + 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        push,
   input  logic [ADDR_WIDTH-1:0]       push_addr,
   input  logic [DATA_WIDTH-1:0]       push_data,
   input  logic                        pop,
   output logic [CNT_W-1:0]            count,
   output logic                        full,
   output logic                        empty,
   output logic [ADDR_WIDTH-1:0]       head_addr,
   output logic [DATA_WIDTH-1:0]       head_data,
   output logic [DEPTH*ADDR_WIDTH-1:0] entry_addrs
);

   logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
   logic [DATA_WIDTH-1:0] data_mem [DEPTH];
   logic [PTR_W-1:0]      rd_ptr;
   logic [PTR_W-1:0]      wr_ptr;
   logic                  do_push;
   logic                  do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   assign head_addr = addr_mem[rd_ptr];
   assign head_data = data_mem[rd_ptr];

   // Storage carries no reset: only pointers/count define which slots are live.
   always_ff @(posedge clk) begin
      if (do_push) begin
         addr_mem[wr_ptr] <= push_addr;
         data_mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // A slot is live when its distance from the read pointer is below count.
   always_comb begin
      logic [PTR_W-1:0] off;
      off         = '0;
      entry_addrs = '0;
      for (int i = 0; i < DEPTH; i++) begin
         off = PTR_W'(i) - rd_ptr;
         if ({1'b0, off} < count)
            entry_addrs[i*ADDR_WIDTH +: ADDR_WIDTH] = addr_mem[i];
      end
   end

endmodule

// File: rtl/regfile_writeback.sv
// -----------------------------------------------------------------------------
// regfile_writeback
// Write-side driver for the CPU register file. Merges the single-cycle ALU
// result path (no backpressure) with the memory/load path (valid/ready into a
// small FIFO), arbitrates with starvation protection, drives the single
// registered write port and reports per-register pending-write (busy) status.
// Ports:
//   clk, rst                         : clock, asynchronous active-high reset
//   alu_valid/alu_addr/alu_data      : ALU result; alu_stall -> ALU must hold
//   mem_valid/mem_addr/mem_data      : memory result; mem_ready -> accepted
//   write_en/write_address_0/write_data : registered register-file write port
//   query_addr_0/1, busy_0/1         : hazard queries against in-flight writes
// Optional build macro WB_BYPASS_EN adds fwd_hit_0/1 and fwd_data_0/1 so a
// same-cycle register-file read can take the value being written; under a
// forward hit busy_n then reflects buffered FIFO entries only.
// -----------------------------------------------------------------------------
module regfile_writeback #(
   parameter int DATA_WIDTH   = cpu_pkg::DATA_WIDTH,
   parameter int ADDR_WIDTH   = cpu_pkg::ADDR_WIDTH,
   parameter int FIFO_DEPTH   = 4,
   parameter int STARVE_LIMIT = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  alu_valid,
   input  logic [ADDR_WIDTH-1:0] alu_addr,
   input  logic [DATA_WIDTH-1:0] alu_data,
   output logic                  alu_stall,
   input  logic                  mem_valid,
   output logic                  mem_ready,
   input  logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_data,
   output logic                  write_en,
   output logic [ADDR_WIDTH-1:0] write_address_0,
   output logic [DATA_WIDTH-1:0] write_data,
   input  logic [ADDR_WIDTH-1:0] query_addr_0,
   input  logic [ADDR_WIDTH-1:0] query_addr_1,
   output logic                  busy_0,
   output logic                  busy_1
`ifdef WB_BYPASS_EN
   ,
   output logic                  fwd_hit_0,
   output logic                  fwd_hit_1,
   output logic [DATA_WIDTH-1:0] fwd_data_0,
   output logic [DATA_WIDTH-1:0] fwd_data_1
`endif
);

   import cpu_pkg::*;

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int SC_W  = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(REG_ZERO);

   logic [CNT_W-1:0]                 fifo_count;
   logic                             fifo_full;
   logic                             fifo_empty;
   logic [ADDR_WIDTH-1:0]            head_addr;
   logic [DATA_WIDTH-1:0]            head_data;
   logic [FIFO_DEPTH*ADDR_WIDTH-1:0] entry_addrs;
   logic                             fifo_push;
   logic [SC_W-1:0]                  starve_cnt;
   logic                             alu_req;
   logic                             alu_win;
   logic                             fifo_win;

   function automatic logic fifo_has(input logic [ADDR_WIDTH-1:0]            q,
                                     input logic [FIFO_DEPTH*ADDR_WIDTH-1:0] vec);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++)
         if (vec[i*ADDR_WIDTH +: ADDR_WIDTH] == q) hit = 1'b1;
      return hit;
   endfunction

   // Ready depends on occupancy only: a same-cycle pop does not free a slot.
   assign mem_ready = !rst && (fifo_count < CNT_W'(FIFO_DEPTH));
   assign fifo_push = mem_valid && mem_ready && !fifo_full;

   wb_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .DEPTH      (FIFO_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push        (fifo_push),
      .push_addr   (mem_addr),
      .push_data   (mem_data),
      .pop         (fifo_win),
      .count       (fifo_count),
      .full        (fifo_full),
      .empty       (fifo_empty),
      .head_addr   (head_addr),
      .head_data   (head_data),
      .entry_addrs (entry_addrs)
   );

   // Arbitration: writes to x0 are not requests. The starve counter only
   // builds while the FIFO is non-empty, so an empty FIFO never blocks the ALU.
   assign alu_req   = alu_valid && (alu_addr != ZERO_ADDR);
   assign alu_win   = alu_req && ((starve_cnt < SC_W'(STARVE_LIMIT)) || fifo_empty);
   assign fifo_win  = !alu_win && !fifo_empty;
   assign alu_stall = alu_req && fifo_win;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (fifo_win || fifo_empty) begin
         starve_cnt <= '0;
      end else if (alu_win && (starve_cnt < SC_W'(STARVE_LIMIT))) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end

   // ---- output stage: winning request -> register-file write port ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         write_en        <= 1'b0;
         write_address_0 <= '0;
         write_data      <= '0;
      end else if (alu_win) begin
         write_en        <= 1'b1;
         write_address_0 <= alu_addr;
         write_data      <= alu_data;
      end else if (fifo_win) begin
         // An x0 head is consumed but never written.
         write_en        <= (head_addr != ZERO_ADDR);
         write_address_0 <= head_addr;
         write_data      <= head_data;
      end else begin
         write_en        <= 1'b0;
      end
   end

   // ---- hazard status from current state (same-cycle push not visible) ----
   logic out_hit_0;
   logic out_hit_1;
   assign out_hit_0 = write_en && (write_address_0 == query_addr_0);
   assign out_hit_1 = write_en && (write_address_0 == query_addr_1);

`ifdef WB_BYPASS_EN
   assign fwd_hit_0  = out_hit_0 && (query_addr_0 != ZERO_ADDR);
   assign fwd_hit_1  = out_hit_1 && (query_addr_1 != ZERO_ADDR);
   assign fwd_data_0 = write_data;
   assign fwd_data_1 = write_data;

   // The output-stage value is forwarded, so only buffered entries are busy.
   assign busy_0 = (query_addr_0 != ZERO_ADDR) &&
                   (fifo_has(query_addr_0, entry_addrs) || (out_hit_0 && !fwd_hit_0));
   assign busy_1 = (query_addr_1 != ZERO_ADDR) &&
                   (fifo_has(query_addr_1, entry_addrs) || (out_hit_1 && !fwd_hit_1));
`else
   assign busy_0 = (query_addr_0 != ZERO_ADDR) &&
                   (fifo_has(query_addr_0, entry_addrs) || out_hit_0);
   assign busy_1 = (query_addr_1 != ZERO_ADDR) &&
                   (fifo_has(query_addr_1, entry_addrs) || out_hit_1);
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
module tb_regfile_writeback;
   import cpu_pkg::*;

   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int DEPTH = 4;
   localparam int LIMIT = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          alu_valid;
   logic [AW-1:0] alu_addr;
   logic [DW-1:0] alu_data;
   logic          alu_stall;
   logic          mem_valid;
   logic          mem_ready;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_data;
   logic          write_en;
   logic [AW-1:0] write_address_0;
   logic [DW-1:0] write_data;
   logic [AW-1:0] query_addr_0;
   logic [AW-1:0] query_addr_1;
   logic          busy_0;
   logic          busy_1;
`ifdef WB_BYPASS_EN
   logic          fwd_hit_0;
   logic          fwd_hit_1;
   logic [DW-1:0] fwd_data_0;
   logic [DW-1:0] fwd_data_1;
`endif

   always #5 clk = ~clk;

   regfile_writeback #(
      .DATA_WIDTH   (DW),
      .ADDR_WIDTH   (AW),
      .FIFO_DEPTH   (DEPTH),
      .STARVE_LIMIT (LIMIT)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .alu_valid       (alu_valid),
      .alu_addr        (alu_addr),
      .alu_data        (alu_data),
      .alu_stall       (alu_stall),
      .mem_valid       (mem_valid),
      .mem_ready       (mem_ready),
      .mem_addr        (mem_addr),
      .mem_data        (mem_data),
      .write_en        (write_en),
      .write_address_0 (write_address_0),
      .write_data      (write_data),
      .query_addr_0    (query_addr_0),
      .query_addr_1    (query_addr_1),
      .busy_0          (busy_0),
      .busy_1          (busy_1)
`ifdef WB_BYPASS_EN
      ,
      .fwd_hit_0       (fwd_hit_0),
      .fwd_hit_1       (fwd_hit_1),
      .fwd_data_0      (fwd_data_0),
      .fwd_data_1      (fwd_data_1)
`endif
   );

   int checks = 0;
   int errors = 0;

   // Reference model: pending memory results as a queue, plus the visible
   // write-port contents and the number of consecutive ALU wins over a
   // waiting FIFO.
   wb_req_t       mq[$];
   int            starve_m;
   logic          m_we;
   logic [AW-1:0] m_wa;
   logic [DW-1:0] m_wd;

   wb_req_t       dut_log[$];
   logic          s_we, s_stall, s_ready, s_busy0, s_busy1;
`ifdef WB_BYPASS_EN
   logic          s_fwd0;
   logic [DW-1:0] s_fwdd0;
`endif

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic m_busy(input logic [AW-1:0] q);
      if (q == '0) return 1'b0;
      foreach (mq[i]) if (mq[i].addr == q) return 1'b1;
`ifdef WB_BYPASS_EN
      return 1'b0;
`else
      return m_we && (m_wa == q);
`endif
   endfunction

   task automatic model_reset();
      mq.delete();
      starve_m = 0;
      m_we     = 1'b0;
      m_wa     = '0;
      m_wd     = '0;
   endtask

   // One clock cycle: compare every output against the model at the falling
   // edge, advance the model with the inputs of this cycle, then move past
   // the rising edge.
   task automatic tick();
      logic    exp_ready, a_req, a_wins, f_wins, exp_stall, was_empty;
      wb_req_t e;
      @(negedge clk);
      if (rst) model_reset();
      exp_ready = !rst && (mq.size() < DEPTH);
      a_req     = alu_valid && (alu_addr != '0);
      a_wins    = a_req && ((mq.size() == 0) || (starve_m < LIMIT));
      f_wins    = !a_wins && (mq.size() > 0);
      exp_stall = a_req && f_wins;

      chk("write_en", 64'(write_en), 64'(m_we));
      if (m_we || rst) begin
         chk("write_address_0", 64'(write_address_0), 64'(m_wa));
         chk("write_data", 64'(write_data), 64'(m_wd));
      end
      chk("mem_ready", 64'(mem_ready), 64'(exp_ready));
      chk("alu_stall", 64'(alu_stall), 64'(exp_stall));
      chk("busy_0", 64'(busy_0), 64'(m_busy(query_addr_0)));
      chk("busy_1", 64'(busy_1), 64'(m_busy(query_addr_1)));
`ifdef WB_BYPASS_EN
      chk("fwd_hit_0", 64'(fwd_hit_0), 64'(m_we && m_wa == query_addr_0 && query_addr_0 != '0));
      chk("fwd_hit_1", 64'(fwd_hit_1), 64'(m_we && m_wa == query_addr_1 && query_addr_1 != '0));
      if (m_we) chk("fwd_data_0", 64'(fwd_data_0), 64'(m_wd));
      s_fwd0  = fwd_hit_0;
      s_fwdd0 = fwd_data_0;
`endif
      s_we    = write_en;
      s_stall = alu_stall;
      s_ready = mem_ready;
      s_busy0 = busy_0;
      s_busy1 = busy_1;
      if (write_en) dut_log.push_back(wb_req_t'({write_address_0, write_data}));

      if (!rst) begin
         was_empty = (mq.size() == 0);
         if (a_wins) begin
            m_we = 1'b1; m_wa = alu_addr; m_wd = alu_data;
         end else if (f_wins) begin
            e = mq.pop_front();
            m_we = (e.addr != '0); m_wa = e.addr; m_wd = e.data;
         end else begin
            m_we = 1'b0;
         end
         if (f_wins || was_empty) starve_m = 0;
         else if (a_wins && starve_m < LIMIT) starve_m++;
         if (mem_valid && exp_ready) mq.push_back(wb_req_t'({mem_addr, mem_data}));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
      mem_valid = 1'b0; mem_addr = '0; mem_data = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      int         n;
      int         stall_cnt;
      int         stall_at;
      logic       seen;
      wb_req_t    got[$];
      logic [4:0] fa [4];
      logic [31:0] fd [4];

      fa = '{5'd5, 5'd6, 5'd7, 5'd8};
      fd = '{32'hA5, 32'hB6, 32'hC7, 32'hD8};

      rst = 1'b1;
      idle();
      query_addr_0 = '0;
      query_addr_1 = '0;
      model_reset();

      // Reset state
      tick();
      chk("reset_write_en", 64'(write_en), 64'(0));
      chk("reset_write_addr", 64'(write_address_0), 64'(0));
      chk("reset_write_data", 64'(write_data), 64'(0));
      chk("reset_mem_ready", 64'(mem_ready), 64'(0));
      chk("reset_alu_stall", 64'(alu_stall), 64'(0));
      rst = 1'b0;
      tick();

      // Reset mid-stream discards buffered results
      dut_log.delete();
      alu_valid = 1'b1; alu_addr = 5'd2; alu_data = 32'h22;
      for (int k = 0; k < 3; k++) begin
         mem_valid = 1'b1; mem_addr = 5'(20 + k); mem_data = 32'(k + 1);
         tick();
      end
      mem_valid = 1'b0;
      rst = 1'b1;
      tick();
      chk("midrst_mem_ready", 64'(s_ready), 64'(0));
      chk("midrst_write_en", 64'(s_we), 64'(0));
      rst = 1'b0;
      alu_valid = 1'b0;
      query_addr_0 = 5'd20;
      repeat (8) tick();
      n = 0;
      foreach (dut_log[i]) if (dut_log[i].addr >= 5'd20 && dut_log[i].addr <= 5'd22) n++;
      chk("midrst_discarded", 64'(n), 64'(0));
      chk("midrst_busy_20", 64'(s_busy0), 64'(0));

      // Fill to full with the ALU streaming to x1
      idle();
      query_addr_0 = '0;
      dut_log.delete();
      alu_valid = 1'b1; alu_addr = 5'd1; alu_data = 32'h11;
      for (int k = 0; k < 4; k++) begin
         mem_valid = 1'b1; mem_addr = fa[k]; mem_data = fd[k];
         tick();
         chk($sformatf("fill_ready_%0d", k), 64'(s_ready), 64'(1));
      end
      mem_valid = 1'b0;
      tick();
      chk("full_mem_ready", 64'(s_ready), 64'(0));
      chk("full_forced_stall", 64'(s_stall), 64'(1));
      repeat (16) tick();
      alu_valid = 1'b0;
      repeat (4) tick();
      got.delete();
      foreach (dut_log[i]) if (dut_log[i].addr != 5'd1) got.push_back(dut_log[i]);
      chk("fill_write_count", 64'(got.size()), 64'(4));
      for (int k = 0; k < 4; k++)
         if (k < got.size())
            chk($sformatf("fill_order_%0d", k), 64'(got[k]), 64'({fa[k], fd[k]}));

      // Starvation: FIFO holds (9,0x99) while the ALU streams x3
      idle();
      alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'h333;
      mem_valid = 1'b1; mem_addr = 5'd9; mem_data = 32'h99;
      tick();
      mem_valid = 1'b0;
      dut_log.delete();
      stall_cnt = 0;
      stall_at  = -1;
      for (int k = 1; k <= 6; k++) begin
         tick();
         if (s_stall) begin stall_cnt++; stall_at = k; end
      end
      idle();
      // First entry is the write from the push cycle, then three more ALU
      // wins, the forced FIFO write, and the held ALU result.
      chk("starve_stall_cycles", 64'(stall_cnt), 64'(1));
      chk("starve_stall_at", 64'(stall_at), 64'(4));
      chk("starve_log_size", 64'(dut_log.size()), 64'(6));
      if (dut_log.size() == 6) begin
         for (int k = 0; k < 4; k++)
            chk($sformatf("starve_alu_%0d", k), 64'(dut_log[k].addr), 64'(3));
         chk("starve_fifo_write", 64'(dut_log[4]), 64'({5'd9, 32'h99}));
         chk("starve_alu_after", 64'(dut_log[5]), 64'({5'd3, 32'h333}));
      end
      repeat (2) tick();

      // Register x0 filtering
      dut_log.delete();
      query_addr_0 = '0;
      alu_valid = 1'b1; alu_addr = '0; alu_data = 32'hFFFF_FFFF;
      mem_valid = 1'b1; mem_addr = '0; mem_data = 32'h5555;
      tick();
      mem_valid = 1'b0;
      seen = 1'b0;
      repeat (4) begin
         tick();
         seen = seen | s_busy0;
      end
      idle();
      chk("x0_no_writes", 64'(dut_log.size()), 64'(0));
      chk("x0_busy_never", 64'(seen), 64'(0));

      // Busy tracking for a buffered memory result
      query_addr_0 = 5'd12;
      query_addr_1 = 5'd13;
      mem_valid = 1'b1; mem_addr = 5'd12; mem_data = 32'h1234;
      tick();
      seen = s_busy1;
      chk("busy_push_cycle", 64'(s_busy0), 64'(0));
      mem_valid = 1'b0;
      tick();
      seen = seen | s_busy1;
      chk("busy_in_fifo", 64'(s_busy0), 64'(1));
      tick();
      seen = seen | s_busy1;
      chk("busy_write_cycle_we", 64'(s_we), 64'(1));
`ifdef WB_BYPASS_EN
      chk("busy_write_cycle", 64'(s_busy0), 64'(0));
`else
      chk("busy_write_cycle", 64'(s_busy0), 64'(1));
`endif
      tick();
      seen = seen | s_busy1;
      chk("busy_after_write", 64'(s_busy0), 64'(0));
      chk("busy_1_never", 64'(seen), 64'(0));

`ifdef WB_BYPASS_EN
      // Forwarding of the value being written
      query_addr_0 = 5'd4;
      alu_valid = 1'b1; alu_addr = 5'd4; alu_data = 32'hDEAD_BEEF;
      tick();
      alu_valid = 1'b0;
      tick();
      chk("fwd_hit_0_lit", 64'(s_fwd0), 64'(1));
      chk("fwd_data_0_lit", 64'(s_fwdd0), 64'(32'hDEAD_BEEF));
      chk("fwd_busy_0_lit", 64'(s_busy0), 64'(0));
`endif

      // Randomized traffic against the model
      idle();
      for (int c = 0; c < 3000; c++) begin
         rst = ($urandom_range(0, 299) == 0);
         if (!s_stall) begin
            alu_valid = ($urandom_range(0, 9) < 6);
            alu_addr  = AW'($urandom_range(0, 15));
            alu_data  = $urandom;
         end
         if (!(mem_valid && !s_ready)) begin
            mem_valid = ($urandom_range(0, 1) == 1);
            mem_addr  = AW'($urandom_range(0, 15));
            mem_data  = $urandom;
         end
         query_addr_0 = AW'($urandom_range(0, 15));
         query_addr_1 = AW'($urandom_range(0, 15));
         tick();
      end
      rst = 1'b0;
      idle();
      repeat (12) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
